// File: rtl/param_seq_detector_mealy.sv
`default_nettype none
// ============================================================================
// Module      : param_seq_detector_mealy
// Description : Parametrised Mealy serial-pattern detector with runtime
//               overlap mode, pattern reload and saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module param_seq_detector_mealy #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter int                     CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in,
    input  logic                   in_valid,
    input  logic                   overlap,
    input  logic                   pat_load,
    input  logic [PATTERN_LEN-1:0] pat_in,
    input  logic                   cnt_clr,
    output logic                   out,
    output logic [CNT_W-1:0]       match_cnt
);

    localparam int                FILL_W     = $clog2(PATTERN_LEN);
    localparam logic [FILL_W-1:0] c_FILL_MAX = FILL_W'(PATTERN_LEN - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};

    logic [PATTERN_LEN-1:0] r_pat;
    logic [PATTERN_LEN-2:0] r_hist;
    logic [FILL_W-1:0]      r_fill;
    logic [CNT_W-1:0]       r_cnt;

    logic [PATTERN_LEN-1:0] w_pat_nxt;
    logic [PATTERN_LEN-2:0] w_hist_nxt;
    logic [FILL_W-1:0]      w_fill_nxt;
    logic [PATTERN_LEN-1:0] w_window;
    logic                   w_out;

    // Candidate window: stored history with the current bit appended as LSB.
    assign w_window = {r_hist, in};
    assign w_out    = rst & in_valid & ~pat_load & (r_fill == c_FILL_MAX)
                    & (w_window == r_pat);

    always_comb begin
        w_pat_nxt  = r_pat;
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        if (pat_load) begin
            w_pat_nxt  = pat_in;
            w_hist_nxt = '0;
            w_fill_nxt = '0;
        end else if (in_valid) begin
            w_hist_nxt = w_window[PATTERN_LEN-2:0];
            if (w_out && !overlap) begin
                w_fill_nxt = '0;
            end else if (r_fill != c_FILL_MAX) begin
                w_fill_nxt = r_fill + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat  <= PATTERN;
            r_hist <= '0;
            r_fill <= '0;
        end else begin
            r_pat  <= w_pat_nxt;
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
        end
    end

    // Clear beats a coincident match; count sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_out && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out       = w_out;
    assign match_cnt = r_cnt;

endmodule
`default_nettype wire
